// File: rtl/bus_slave_responder_if.sv
// Request/response bundle for the bus slave responder.
// master: requester side; slave: responder side.
interface bus_slave_responder_if #(
  parameter int DATA_WIDTH       = 8,
  parameter int SLAVE_ADDR_WIDTH = 13
);
  logic                        req_valid;
  logic                        req_mode;
  logic [SLAVE_ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0]       req_wdata;
  logic                        req_ready;
  logic                        rsp_valid;
  logic [DATA_WIDTH-1:0]       rsp_rdata;
  logic                        rsp_err;

  modport master (
    output req_valid, req_mode, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_mode, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/bus_slave_responder.sv
// Bus slave responder: one request, WAIT_CYCLES waits, local memory access, 1-cycle rsp.
// Ports: clk, rstn (sync, active-low), bus (slave modport: req_* in, req_ready/rsp_* out).
// Optional: BUS_SLAVE_ADDR_CHECK_EN flags upper address bits as an error.
module bus_slave_responder #(
  parameter int DATA_WIDTH       = 8,
  parameter int SLAVE_ADDR_WIDTH = 13,
  parameter int MEM_ADDR_WIDTH   = 6,
  parameter int WAIT_CYCLES      = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  bus_slave_responder_if.slave  bus
);

  localparam logic [7:0] WC    = 8'(WAIT_CYCLES);
  localparam int         DEPTH = 1 << MEM_ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    RESP
  } state_t;

  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  logic                        mode_q;
  logic [SLAVE_ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]       wdata_q;
  logic [DATA_WIDTH-1:0]       rdata_q;
  logic                        err_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                      accept;
  logic                      addr_err;
  logic [MEM_ADDR_WIDTH-1:0] idx;
  logic [DATA_WIDTH-1:0]     rd_val;

  assign accept = bus.req_valid && (state_q == IDLE);
  assign idx    = addr_q[MEM_ADDR_WIDTH-1:0];

`ifdef BUS_SLAVE_ADDR_CHECK_EN
  if (MEM_ADDR_WIDTH < SLAVE_ADDR_WIDTH) begin : g_chk
    assign addr_err = |addr_q[SLAVE_ADDR_WIDTH-1:MEM_ADDR_WIDTH];
  end else begin : g_nochk
    assign addr_err = 1'b0;
  end
`else
  assign addr_err = 1'b0;
  // Upper bits alias onto the memory index.
  if (MEM_ADDR_WIDTH < SLAVE_ADDR_WIDTH) begin : g_alias
    logic unused_hi;
    assign unused_hi = ^addr_q[SLAVE_ADDR_WIDTH-1:MEM_ADDR_WIDTH];
  end
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (WC == 8'd0) begin
            state_d = ACCESS;
          end else begin
            state_d = WAIT;
            cnt_d   = WC;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) state_d = ACCESS;
      end
      ACCESS: state_d = RESP;
      RESP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): bus.req_ready = 1'b1;
      (state_q == RESP): bus.rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  always_comb begin
    if (addr_err)    rd_val = '1;
    else if (mode_q) rd_val = wdata_q;
    else             rd_val = mem[idx];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      mode_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        mode_q  <= bus.req_mode;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (state_q == ACCESS) begin
        rdata_q <= rd_val;
        err_q   <= addr_err;
      end
    end
  end

  // No reset on storage; a reset on the access edge suppresses the write.
  always_ff @(posedge clk) begin
    if (rstn && state_q == ACCESS && mode_q && !addr_err)
      mem[idx] <= wdata_q;
  end

endmodule

// File: tb/tb_bus_slave_responder.sv
// Self-checking bench for bus_slave_responder: WAIT_CYCLES=2 and =0 instances.
// Expected data comes from an array memory model with aliasing/error rules.
module tb_bus_slave_responder;

  logic        clk = 1'b0;
  logic        rstn;
  logic        sel;
  logic        req_valid;
  logic        req_mode;
  logic [12:0] req_addr;
  logic [7:0]  req_wdata;

  logic       ready, rv, re;
  logic [7:0] rd;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mem_m [2][64];
  bit         known [2][64];

  always #5 clk = ~clk;

  bus_slave_responder_if #(.DATA_WIDTH(8), .SLAVE_ADDR_WIDTH(13)) bus0 ();
  bus_slave_responder_if #(.DATA_WIDTH(8), .SLAVE_ADDR_WIDTH(13)) bus1 ();

  assign bus0.req_valid = req_valid & ~sel;
  assign bus0.req_mode  = req_mode;
  assign bus0.req_addr  = req_addr;
  assign bus0.req_wdata = req_wdata;
  assign bus1.req_valid = req_valid & sel;
  assign bus1.req_mode  = req_mode;
  assign bus1.req_addr  = req_addr;
  assign bus1.req_wdata = req_wdata;

  assign ready = sel ? bus1.req_ready : bus0.req_ready;
  assign rv    = sel ? bus1.rsp_valid : bus0.rsp_valid;
  assign rd    = sel ? bus1.rsp_rdata : bus0.rsp_rdata;
  assign re    = sel ? bus1.rsp_err   : bus0.rsp_err;

  bus_slave_responder #(
    .DATA_WIDTH(8), .SLAVE_ADDR_WIDTH(13),
    .MEM_ADDR_WIDTH(6), .WAIT_CYCLES(2)
  ) u_w2 (
    .clk(clk), .rstn(rstn), .bus(bus0.slave)
  );

  bus_slave_responder #(
    .DATA_WIDTH(8), .SLAVE_ADDR_WIDTH(13),
    .MEM_ADDR_WIDTH(6), .WAIT_CYCLES(0)
  ) u_w0 (
    .clk(clk), .rstn(rstn), .bus(bus1.slave)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: compute expected response and update memory for one request.
  task automatic model(input bit s, input bit m,
                       input logic [12:0] a, input logic [7:0] wd,
                       output logic [7:0] ed, output bit ee,
                       output bit chk_d);
    int idx;
    idx   = int'(a[5:0]);
    ee    = 1'b0;
    chk_d = 1'b1;
    ed    = 8'h00;
`ifdef BUS_SLAVE_ADDR_CHECK_EN
    if (a[12:6] != 7'd0) begin
      ee = 1'b1;
      ed = 8'hFF;
      return;
    end
`endif
    if (m) begin
      mem_m[s][idx] = wd;
      known[s][idx] = 1'b1;
      ed = wd;
    end else begin
      ed    = mem_m[s][idx];
      chk_d = known[s][idx];
    end
  endtask

  task automatic txn(input bit s, input bit m,
                     input logic [12:0] a, input logic [7:0] wd,
                     output logic [7:0] got);
    int w;
    int n;
    logic [7:0] ed;
    bit ee, chk_d;
    w = s ? 0 : 2;
    model(s, m, a, wd, ed, ee, chk_d);
    @(negedge clk);
    sel = s; req_mode = m; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    n = 0;
    while (ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", 32'(n < 50), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("ready_low", 32'(ready), 32'd0);
    n = 0;
    while (rv !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, w + 1);
    chk("err", 32'(re), 32'(ee));
    if (chk_d) chk("data", 32'(rd), 32'(ed));
    got = rd;
    @(negedge clk);
    chk("pulse_end", 32'(rv), 32'd0);
    chk("ready_back", 32'(ready), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] got;
    logic [7:0] ed;
    bit ee, chk_d;
    bit          t3_m [4];
    logic [12:0] t3_a [4];
    logic [7:0]  t3_d [4];
    logic [7:0]  exp_q [$];
    int idx, cyc, last_acc, pulses, n;
    bit loadn;

    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 64; i++) begin
        mem_m[s][i] = 8'h00;
        known[s][i] = 1'b0;
      end

    rstn = 1'b0; sel = 1'b0; req_valid = 1'b0;
    req_mode = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready0", 32'(bus0.req_ready), 32'd1);
    chk("rst_valid0", 32'(bus0.rsp_valid), 32'd0);
    chk("rst_rdata0", 32'(bus0.rsp_rdata), 32'd0);
    chk("rst_err0",   32'(bus0.rsp_err),   32'd0);
    chk("rst_ready1", 32'(bus1.req_ready), 32'd1);
    chk("rst_valid1", 32'(bus1.rsp_valid), 32'd0);
    rstn = 1'b1;

    // Write then reads, including an unwritten location.
    txn(0, 1, 13'h003, 8'hA5, got);
    chk("t1_wdata", 32'(got), 32'hA5);
    txn(0, 0, 13'h003, 8'h00, got);
    chk("t2_rdata", 32'(got), 32'hA5);
    txn(0, 0, 13'h004, 8'h00, got);
    chk("t2_rv_notx", 32'($isunknown(rv)), 32'd0);

    // Back-to-back requests with req_valid held high.
    t3_m = '{1'b1, 1'b0, 1'b1, 1'b0};
    t3_a = '{13'h010, 13'h010, 13'h011, 13'h011};
    t3_d = '{8'h21, 8'h00, 8'h42, 8'h00};
    @(negedge clk);
    sel = 1'b0;
    req_mode = t3_m[0]; req_addr = t3_a[0]; req_wdata = t3_d[0];
    req_valid = 1'b1;
    idx = 0; cyc = 0; last_acc = -1; pulses = 0; loadn = 1'b0;
    repeat (40) begin
      if (cyc > 0) @(negedge clk);
      cyc++;
      if (loadn) begin
        loadn = 1'b0;
        if (idx < 4) begin
          req_mode = t3_m[idx]; req_addr = t3_a[idx]; req_wdata = t3_d[idx];
        end else begin
          req_valid = 1'b0;
        end
      end
      if (rv === 1'b1) begin
        pulses++;
        if (exp_q.size() > 0) chk("t3_data", 32'(rd), 32'(exp_q.pop_front()));
      end
      if (ready === 1'b1 && req_valid) begin
        if (last_acc >= 0) chk("t3_gap", cyc - last_acc, 5);
        last_acc = cyc;
        model(0, t3_m[idx], t3_a[idx], t3_d[idx], ed, ee, chk_d);
        exp_q.push_back(ed);
        idx++;
        loadn = 1'b1;
      end
    end
    req_valid = 1'b0;
    chk("t3_pulses", pulses, 4);
    chk("t3_accepts", idx, 4);

    // Reset during WAIT aborts the write.
    txn(0, 1, 13'h007, 8'h11, got);
    @(negedge clk);
    sel = 1'b0; req_mode = 1'b1; req_addr = 13'h007; req_wdata = 8'h3C;
    req_valid = 1'b1;
    n = 0;
    while (ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    chk("t4_rv",    32'(rv),    32'd0);
    chk("t4_ready", 32'(ready), 32'd1);
    chk("t4_rdata", 32'(rd),    32'd0);
    chk("t4_err",   32'(re),    32'd0);
    rstn = 1'b1;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (rv !== 1'b0) pulses++;
    end
    chk("t4_no_rsp", pulses, 0);
    txn(0, 0, 13'h007, 8'h00, got);
    chk("t4_read", 32'(got), 32'h11);

    // Out-of-range address: error or alias.
    txn(0, 1, 13'h043, 8'h5A, got);
    txn(0, 0, 13'h003, 8'h00, got);
`ifdef BUS_SLAVE_ADDR_CHECK_EN
    chk("t5_read", 32'(got), 32'hA5);
`else
    chk("t5_read", 32'(got), 32'h5A);
`endif

    // Zero wait states.
    txn(1, 1, 13'h03F, 8'h96, got);
    txn(1, 0, 13'h03F, 8'h00, got);
    chk("t6_read", 32'(got), 32'h96);

    // Random traffic on both instances.
    repeat (60) begin
      bit s, m;
      logic [12:0] a;
      s = 1'($urandom_range(0, 1));
      m = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) a = 13'($urandom);
      else a = 13'($urandom_range(0, 63));
      txn(s, m, a, 8'($urandom), got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
